// File: rtl/tis_pkg.sv
// Shared constants and types for the TIS core array and its boot loader.
// Latency: n/a (package only).
// Backpressure: n/a.
package tis_pkg;

    localparam int N_CORES    = 12;      // cores / ROM blocks
    localparam int PROG_DEPTH = 15;      // instruction slots per core
    localparam int WORD_W     = 16;      // instruction width
    localparam int ROM_AW     = 8;       // 2^ROM_AW >= N_CORES*PROG_DEPTH + 1
    localparam int CORE_W     = $clog2(N_CORES);
    localparam int SLOT_W     = 4;

    localparam logic [WORD_W-1:0] END_WORD = 16'hFFFF;

    // Checksum word sits just past the last program block.
    localparam logic [ROM_AW-1:0] CHK_ADDR = ROM_AW'(N_CORES * PROG_DEPTH);

    // Program length, shared with the core's pLength input.
    typedef logic [3:0] plen_t;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        CAPT,
        SKIP,
        CHK,
        DONE
    } loader_state_e;

endpackage

// File: rtl/prog_addr_gen.sv
// Core/slot counters for the program loader; drives the ROM read address.
// Latency: rom_addr is combinational from the registered counters (0 cycles).
// Backpressure: none; counters move only on the loader's explicit strobes.
// Ports: clr/slot_inc/core_inc/chk_sel control in; core, slot, rom_addr,
//        slot_last, core_last out.
module prog_addr_gen
    import tis_pkg::*;
(
    input  logic              clk,
    input  logic              rst,        // async, active-low
    input  logic              clr,        // restart at core 0 slot 0
    input  logic              slot_inc,   // next slot of same core
    input  logic              core_inc,   // next core, slot back to 0
    input  logic              chk_sel,    // point at the checksum word
    output logic [CORE_W-1:0] core,
    output logic [SLOT_W-1:0] slot,
    output logic [ROM_AW-1:0] rom_addr,
    output logic              slot_last,
    output logic              core_last
);

    logic [CORE_W-1:0] core_q;
    logic [SLOT_W-1:0] slot_q;
    // Block base address kept as a running sum so no multiplier is needed.
    logic [ROM_AW-1:0] base_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            core_q <= '0;
            slot_q <= '0;
            base_q <= '0;
        end else if (clr) begin
            core_q <= '0;
            slot_q <= '0;
            base_q <= '0;
        end else if (core_inc) begin
            core_q <= core_q + CORE_W'(1);
            slot_q <= '0;
            base_q <= base_q + ROM_AW'(PROG_DEPTH);
        end else if (slot_inc) begin
            slot_q <= slot_q + SLOT_W'(1);
        end
    end

    assign core      = core_q;
    assign slot      = slot_q;
    assign rom_addr  = chk_sel ? CHK_ADDR : (base_q + ROM_AW'(slot_q));
    assign slot_last = (slot_q == SLOT_W'(PROG_DEPTH - 1));
    assign core_last = (core_q == CORE_W'(N_CORES - 1));

endmodule

// File: rtl/prog_loader.sv
// Boot loader: walks the program ROM, writes every core's slots, sets plen, then releases core_rst.
// Latency: 2 cycles per word or terminator, 1 per core advance (+2 for checksum); 372 cycles for a full load.
// Backpressure: none; start is ignored while busy, ROM data is assumed valid 1 cycle after rom_addr.
// Ports: start/busy/done handshake, rom_addr/rom_data ROM port, wr_* instruction write port,
//        plen packed lengths (core k at [4k+3:4k]), core_rst to the array, err checksum flag.
// Optional: define PROG_LOADER_CHECKSUM_EN to verify the word after the last block against a running sum.
module prog_loader
    import tis_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,        // async, active-low
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [ROM_AW-1:0]     rom_addr,
    input  logic [WORD_W-1:0]     rom_data,
    output logic                  wr_en,
    output logic [CORE_W-1:0]     wr_core,
    output logic [SLOT_W-1:0]     wr_slot,
    output logic [WORD_W-1:0]     wr_data,
    output logic [N_CORES*4-1:0]  plen,
    output logic                  core_rst,
    output logic                  err
);

    loader_state_e     state_q;
    logic [CORE_W-1:0] core;
    logic [SLOT_W-1:0] slot;
    logic              slot_last;
    logic              core_last;
    logic              is_end;
    logic              clr;
    logic              slot_inc;
    logic              core_inc;
    logic              chk_sel;
    logic              plen_we;
    plen_t             plen_val;
    logic [N_CORES*4-1:0] plen_q;

    assign is_end   = (rom_data == END_WORD);
    // A new load may begin from IDLE or straight out of DONE (reload).
    assign clr      = ((state_q == IDLE) || (state_q == DONE)) && start;
    assign slot_inc = (state_q == CAPT) && !is_end && !slot_last;
    assign core_inc = (state_q == SKIP) && !core_last;

    // Length is recorded either at the terminator or after the last slot.
    assign plen_we  = (state_q == CAPT) && (is_end || slot_last);
    assign plen_val = is_end ? plen_t'(slot) : plen_t'(PROG_DEPTH);

    // Write strobe is decoded in CAPT so it lines up with rom_data.
    assign wr_en    = (state_q == CAPT) && !is_end;
    assign wr_core  = core;
    assign wr_slot  = slot;
    assign wr_data  = rom_data;
    assign plen     = plen_q;

    prog_addr_gen u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .slot_inc  (slot_inc),
        .core_inc  (core_inc),
        .chk_sel   (chk_sel),
        .core      (core),
        .slot      (slot),
        .rom_addr  (rom_addr),
        .slot_last (slot_last),
        .core_last (core_last)
    );

`ifdef PROG_LOADER_CHECKSUM_EN
    logic [WORD_W-1:0] sum_q;
    logic              chk_ph_q;   // 0: address phase, 1: compare phase
    logic              err_q;

    assign chk_sel = (state_q == CHK);
    assign err     = err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum_q    <= '0;
            chk_ph_q <= 1'b0;
            err_q    <= 1'b0;
        end else if (clr) begin
            sum_q    <= '0;
            chk_ph_q <= 1'b0;
            err_q    <= 1'b0;
        end else if (state_q == CAPT) begin
            // Terminators are part of the sum as well.
            sum_q <= sum_q + rom_data;
        end else if (state_q == CHK) begin
            chk_ph_q <= !chk_ph_q;
            if (chk_ph_q) begin
                err_q <= (rom_data != sum_q);
            end
        end
    end
`else
    assign chk_sel = 1'b0;
    assign err     = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            plen_q <= '0;
        end else if (clr) begin
            plen_q <= '0;
        end else if (plen_we) begin
            for (int k = 0; k < N_CORES; k++) begin
                if (core == CORE_W'(k)) begin
                    plen_q[4*k +: 4] <= plen_val;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            core_rst <= 1'b1;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q  <= FETCH;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        core_rst <= 1'b1;
                    end
                end
                FETCH: begin
                    state_q <= CAPT;
                end
                CAPT: begin
                    if (is_end || slot_last) begin
                        state_q <= SKIP;
                    end else begin
                        state_q <= FETCH;
                    end
                end
                SKIP: begin
                    if (core_last) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                        state_q <= CHK;
`else
                        state_q  <= DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        core_rst <= 1'b0;
`endif
                    end else begin
                        state_q <= FETCH;
                    end
                end
`ifdef PROG_LOADER_CHECKSUM_EN
                CHK: begin
                    // Release happens whether or not the checksum matched.
                    if (chk_ph_q) begin
                        state_q  <= DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        core_rst <= 1'b0;
                    end
                end
`endif
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: ROM model, write scoreboard, cycle-accurate done checks.
// Latency: n/a.
// Backpressure: n/a.
module tb_prog_loader;
    import tis_pkg::*;

    logic                 clk;
    logic                 rst;
    logic                 start;
    logic                 busy;
    logic                 done;
    logic [ROM_AW-1:0]    rom_addr;
    logic [WORD_W-1:0]    rom_data;
    logic                 wr_en;
    logic [CORE_W-1:0]    wr_core;
    logic [SLOT_W-1:0]    wr_slot;
    logic [WORD_W-1:0]    wr_data;
    logic [N_CORES*4-1:0] plen;
    logic                 core_rst;
    logic                 err;

    prog_loader dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .wr_en    (wr_en),
        .wr_core  (wr_core),
        .wr_slot  (wr_slot),
        .wr_data  (wr_data),
        .plen     (plen),
        .core_rst (core_rst),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROM: data valid one cycle after the address.
    logic [WORD_W-1:0] rom [0:255];
    always @(posedge clk) rom_data <= rom[rom_addr];

    int total = 0;
    int bad   = 0;

    logic [23:0]          sb[$];           // {core, slot, data}
    int                   wcnt    [N_CORES];
    int                   exp_cnt [N_CORES];
    logic [N_CORES*4-1:0] exp_plen;
    int                   exp_cyc;
    logic                 exp_err;
    logic                 first_seen;
    logic [CORE_W-1:0]    first_core;
    logic [SLOT_W-1:0]    first_slot;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WORD_W-1:0] model_sum();
        logic [WORD_W-1:0] s;
        s = '0;
        for (int c = 0; c < N_CORES; c++) begin
            for (int k = 0; k < PROG_DEPTH; k++) begin
                s = s + rom[c*PROG_DEPTH + k];
                if (rom[c*PROG_DEPTH + k] == END_WORD) break;
            end
        end
        return s;
    endfunction

    // Build expected writes, lengths and load duration from the ROM image.
    task automatic prep_load();
        logic [WORD_W-1:0] w;
        sb.delete();
        exp_plen = '0;
        exp_cyc  = 0;
        for (int c = 0; c < N_CORES; c++) begin
            exp_cnt[c] = 0;
            wcnt[c]    = 0;
            for (int k = 0; k < PROG_DEPTH; k++) begin
                w = rom[c*PROG_DEPTH + k];
                if (w == END_WORD) begin
                    exp_plen[4*c +: 4] = 4'(k);
                    exp_cyc += 2;
                    break;
                end
                sb.push_back({4'(c), 4'(k), w});
                exp_cnt[c]++;
                exp_cyc += 2;
                if (k == PROG_DEPTH - 1) exp_plen[4*c +: 4] = 4'(PROG_DEPTH);
            end
            exp_cyc += 1;
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        exp_cyc += 2;
        exp_err = (rom[N_CORES*PROG_DEPTH] != model_sum());
`else
        exp_err = 1'b0;
`endif
        first_seen = 1'b0;
    endtask

    task automatic run_load();
        int   n;
        logic prev_rst;
        prep_load();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check("busy_after_start", busy, 1);
        check("core_rst_in_load", core_rst, 1);
        check("done_cleared", done, 0);
        n = 0;
        prev_rst = core_rst;
        while (!done && n < 2000) begin
            @(posedge clk);
            #1 n++;
            if (!done) prev_rst = core_rst;
        end
        check("done_cycle", n, exp_cyc);
        check("core_rst_before_done", prev_rst, 1);
        check("core_rst_release", core_rst, 0);
        check("busy_at_done", busy, 0);
        check("plen", plen, exp_plen);
        check("sb_drained", sb.size(), 0);
        for (int c = 0; c < N_CORES; c++) check("writes_per_core", wcnt[c], exp_cnt[c]);
        check("err", err, exp_err);
    endtask

    // Write monitor: every strobe must match the next expected write.
    always @(negedge clk) begin
        logic [23:0] got;
        if (wr_en) begin
            got = {wr_core, wr_slot, wr_data};
            check("wr_not_end_word", (wr_data == END_WORD), 0);
            if (sb.size() == 0) check("wr_unexpected", sb.size(), 1);
            else                check("wr_order", got, sb.pop_front());
            if (int'(wr_core) < N_CORES) wcnt[wr_core]++;
            if (!first_seen) begin
                first_seen = 1'b1;
                first_core = wr_core;
                first_slot = wr_slot;
            end
        end
    end

    initial begin
        rst   = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 256; i++) rom[i] = 16'h1234;
        repeat (2) @(posedge clk);
        #1;
        check("rst_core_rst", core_rst, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_plen", plen, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_rom_addr", rom_addr, 0);
        check("rst_err", err, 0);
        @(negedge clk) rst = 1'b1;
        repeat (2) @(posedge clk);

        // Full load, every word 16'h1234.
        run_load();

        // Reload straight from DONE: core 3 terminates at slot 4.
        for (int i = 0; i < 256; i++) rom[i] = 16'h1000 + 16'(i);
        rom[3*PROG_DEPTH + 4] = END_WORD;
        run_load();
        check("core3_plen", plen[15:12], 4);

        // Empty program on core 0.
        for (int i = 0; i < 256; i++) rom[i] = 16'h2000 + 16'(i * 7);
        rom[0] = END_WORD;
        run_load();
        check("first_wr_core", first_core, 1);
        check("first_wr_slot", first_slot, 0);

        // start held high throughout, then abort with reset mid-load.
        for (int i = 0; i < 256; i++) rom[i] = 16'h3000 + 16'(i);
        prep_load();
        @(negedge clk);
        start = 1'b1;
        repeat (50) @(posedge clk);
        #1;
        check("held_start_busy", busy, 1);
        check("held_start_core_rst", core_rst, 1);
        #2 rst = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_core_rst", core_rst, 1);
        check("abort_wr_en", wr_en, 0);
        check("abort_plen", plen, 0);
        start = 1'b0;
        sb.delete();
        @(negedge clk) rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("post_abort_busy", busy, 0);
        check("post_abort_done", done, 0);
        check("post_abort_core_rst", core_rst, 1);

`ifdef PROG_LOADER_CHECKSUM_EN
        for (int i = 0; i < 256; i++) rom[i] = 16'h4000 + 16'(i * 13);
        rom[5*PROG_DEPTH + 7] = END_WORD;
        rom[N_CORES*PROG_DEPTH] = model_sum();
        run_load();
        check("chk_good_err", err, 0);
        rom[N_CORES*PROG_DEPTH] = model_sum() + 16'd1;
        run_load();
        check("chk_bad_err", err, 1);
        check("chk_bad_done", done, 1);
`else
        // Recovery load after the abort.
        for (int i = 0; i < 256; i++) rom[i] = 16'h5000 + 16'(i);
        run_load();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
